// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
// The result is computed at issue and held; busy/done model the pipeline stall window.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        read_sel,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | no operation in flight; MTHI/MTLO and new issues accepted
    // RUN   | counter active, pending result held until terminal count

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            load, finish;

    logic [31:0]     hi, lo;
    logic [31:0]     pend_hi, pend_lo;
    logic            pend_wr;

    logic            op_mul, op_div, op_signed;
    logic [63:0]     prod;
    logic [31:0]     abs_a, abs_b, div_b, q_mag, r_mag, quot, rem;
    logic [31:0]     res_hi, res_lo;
    logic            res_wr;

    // ---------------- result datapath ----------------
    always_comb begin
        op_mul    = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        op_div    = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
        op_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
    end

    always_comb begin
        if (op_signed)
            prod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        else
            prod = {32'b0, src_a} * {32'b0, src_b};
    end

    // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow case
    // and gives truncation toward zero with the remainder following the dividend.
    always_comb begin
        abs_a = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
        abs_b = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
        div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag = abs_a / div_b;
        r_mag = abs_a % div_b;
        quot  = (op_signed && (src_a[31] ^ src_b[31])) ? (32'd0 - q_mag) : q_mag;
        rem   = (op_signed && src_a[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        if (op_mul) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
        end else if (op_div) begin
            res_hi = rem;
            res_lo = quot;
            res_wr = (src_b != 32'd0);
        end
    end

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && (op_mul || op_div)) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                    cnt_nxt   = op_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
        endcase
    end

    // ---------------- HI/LO and pending result ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
            end
            if (finish && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            // Moves only land when nothing is in flight; the core stalls them otherwise.
            if (state == IDLE && start && mdu_op == OP_MTHI)
                hi <= src_a;
            if (state == IDLE && start && mdu_op == OP_MTLO)
                lo <= src_a;
        end
    end

    assign busy  = (state == RUN);
    assign rdata = read_sel ? hi : lo;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the MIPS CPU core; owns the HI/LO registers and sequences MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes and MFHI/MFLO reads.
- Sits beside the ALU in the execute stage.
- Exposes a busy/done handshake so the core's control logic stalls HI/LO-dependent instructions until the operation retires.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU; legal range >=1.
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU; legal range >=1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue strobe; sampled on rising edge together with mdu_op, src_a and src_b.
- mdu_op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
- src_a  input  32  rs operand (multiplicand/dividend; MTHI/MTLO data).
- src_b  input  32  rt operand (multiplier/divisor).
- read_sel  input  1  0 selects LO, 1 selects HI.
- rdata  output  32  combinational read of the selected HI/LO register.
- busy  output  1  high while a multiply/divide is in flight.
- done  output  1  single-cycle pulse in the first cycle the new HI/LO values are visible.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, done=0, counter=0, state=IDLE. Takes effect immediately, including mid-operation. The in-flight result is discarded.
- States:
  - IDLE: no operation in flight.
  - RUN: counter active, pending result held.
  - Transitions:
    - IDLE->RUN on an accepted MULT/MULTU/DIV/DIVU.
    - RUN->IDLE when the counter reaches its terminal value.
- Issue acceptance: start=1 and state=IDLE at a rising edge. At that edge:
  - Operands are latched.
  - The pending result is computed and held internally.
  - The counter is loaded with N-1, where N is MULT_CYCLES or DIV_CYCLES.
  - busy=1.
- Latency: busy stays high for exactly N cycles after the issue edge. At the edge ending the Nth busy cycle:
  - HI/LO are written.
  - busy falls.
  - done=1 for that following cycle only.
  - rdata shows the new value in that same cycle.
- start while busy (any op, including MTHI/MTLO): ignored. Counter, pending result and HI/LO are unchanged. The core must stall instead.
- MTHI/MTLO with state=IDLE: at the edge, HI or LO is written with src_a. No busy, no done.
- mdu_op 000/111 with start=1: no effect.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (src_b=0): full DIV_CYCLES busy period, done pulses, HI and LO unchanged.
- rdata is purely combinational from HI/LO and read_sel. During busy it returns the old values; the core must not issue MFHI/MFLO while busy.
- Completion and a new issue are never in the same edge: a new start is accepted no earlier than the edge where done is high.

Test Plan:
1. MULT src_a=0xFFFFFFFF, src_b=0x00000002 -> busy high exactly 5 cycles, then done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
2. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
3. DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Preload HI=0x11111111 and LO=0x22222222 via MTHI/MTLO, then DIVU 7/0 -> busy 10 cycles, done pulses; HI/LO still 0x11111111/0x22222222.
5. MTHI 0x12345678 in IDLE -> rdata (read_sel=1) = 0x12345678 the next cycle, busy stays 0. Then issue MULT and pulse MTLO 0xDEADBEEF during busy -> LO ends with the product, not 0xDEADBEEF.
6. Assert reset=0 mid-way through a DIV (cycle 4 of 10) -> busy=0, HI=LO=0 immediately, no done pulse. After release, MULTU 3*4 accepted -> LO=12, HI=0 after 5 cycles.
